// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: packet codes, state/owner enums and handshake code mapping for usb_tx_sched
package usb_tx_pkg;
  localparam logic [2:0] TX_NONE  = 3'd0;
  localparam logic [2:0] TX_DATA0 = 3'd1;
  localparam logic [2:0] TX_ACK   = 3'd2;
  localparam logic [2:0] TX_NAK   = 3'd3;
  localparam logic [2:0] TX_STALL = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE, GAP} state_t;
  typedef enum logic {HS, DATA} owner_t;

  // 1=ACK, 2=NAK, 3=STALL; 0 is illegal and maps to no packet
  function automatic logic [2:0] hs_to_tx(input logic [1:0] code);
    return code == 2'd1 ? TX_ACK : code == 2'd2 ? TX_NAK : code == 2'd3 ? TX_STALL : TX_NONE;
  endfunction
endpackage

// File: rtl/tx_sched_timer.sv
// tx_sched_timer: 8-bit saturating clear/enable up-counter with a match flag
module tx_sched_timer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       match
);
  logic [7:0] cnt;

  assign match = cnt == limit;

  // Clear has priority; counting stops at all-ones
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != 8'hff) cnt <= cnt + 8'd1;
endmodule

// File: rtl/usb_tx_sched.sv
// usb_tx_sched: fixed-priority handshake/data packet scheduler for the USB 1.1 transmitter
module usb_tx_sched
  import usb_tx_pkg::*;
#(
  parameter int IPG_CLKS      = 16,
  parameter int START_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hs_req,
  input  logic [1:0] hs_code,
  output logic       hs_gnt,
  output logic       hs_done,
  input  logic       data_req,
  output logic       data_gnt,
  output logic       data_done,
  output logic       done_err,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  output logic [2:0] tx_packet,
  output logic       busy
);
  if (IPG_CLKS < 1 || IPG_CLKS > 255) begin : g_bad_ipg
    $error("IPG_CLKS out of range 1..255");
  end
  if (START_TIMEOUT < 1 || START_TIMEOUT > 255) begin : g_bad_to
    $error("START_TIMEOUT out of range 1..255");
  end

  state_t     state;
  owner_t     owner;
  logic [2:0] code_q;
  logic       fail_q;
  logic       active_q;
  logic       fall;
  logic       tim_clr;
  logic       tim_en;
  logic       tim_match;
  logic [7:0] tim_limit;
  logic       fire;
  logic       fire_err;

  assign busy = state != IDLE;
  assign fall = active_q && !tx_transfer_active;

  // One shared timer: held at zero outside ISSUE/GAP so both phases start from 0
  always_comb begin
    tim_limit = state == GAP ? 8'(IPG_CLKS - 1) : 8'(START_TIMEOUT - 1);
    tim_en    = state == ISSUE || state == GAP;
    tim_clr   = state == IDLE || state == ACTIVE || (state == ISSUE && (tx_transfer_active || tim_match));
    fire      = (state == ISSUE && !tx_transfer_active && tim_match) || (state == ACTIVE && fall) || (state == GAP && fail_q);
    fire_err  = state == ACTIVE ? tx_error : 1'b1;
  end

  tx_sched_timer u_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (tim_clr),
    .en    (tim_en),
    .limit (tim_limit),
    .match (tim_match)
  );

  // Scheduler FSM with registered grant/done/packet outputs
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state     <= IDLE;
      owner     <= HS;
      code_q    <= TX_NONE;
      fail_q    <= 1'b0;
      active_q  <= 1'b0;
      tx_packet <= TX_NONE;
      hs_gnt    <= 1'b0;
      data_gnt  <= 1'b0;
      hs_done   <= 1'b0;
      data_done <= 1'b0;
      done_err  <= 1'b0;
    end else begin
      active_q  <= tx_transfer_active;
      hs_gnt    <= 1'b0;
      data_gnt  <= 1'b0;
      hs_done   <= fire && owner == HS;
      data_done <= fire && owner == DATA;
      done_err  <= fire && fire_err;
      case (state)
        IDLE:
          if (hs_req) begin
            hs_gnt    <= 1'b1;
            owner     <= HS;
            code_q    <= hs_to_tx(hs_code);
            tx_packet <= hs_to_tx(hs_code);
            fail_q    <= hs_code == 2'd0;
            state     <= hs_code == 2'd0 ? GAP : ISSUE;
          end else if (data_req) begin
            data_gnt  <= 1'b1;
            owner     <= DATA;
            code_q    <= buffer_occupancy == '0 ? TX_NONE : TX_DATA0;
            tx_packet <= buffer_occupancy == '0 ? TX_NONE : TX_DATA0;
            fail_q    <= buffer_occupancy == '0;
            state     <= buffer_occupancy == '0 ? GAP : ISSUE;
          end
        ISSUE: begin
          tx_packet <= tx_transfer_active || tim_match ? TX_NONE : code_q;
          if (tx_transfer_active) state <= ACTIVE;
          else if (tim_match) state <= GAP;
        end
        ACTIVE:
          if (fall) state <= GAP;
        GAP: begin
          fail_q <= 1'b0;
          if (tim_match) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_usb_tx_sched.sv
// tb_usb_tx_sched: table, hand-written and randomized checks of usb_tx_sched against a timeline model
module tb_usb_tx_sched;
  localparam int IPG = 16;
  localparam int TO  = 64;

  typedef struct {
    logic       hs;
    logic [1:0] code;
    logic       dreq;
    logic [6:0] occ;
    int         dly;
    int         len;
    logic       err;
    logic       never;
  } txn_t;

  typedef struct {
    int pkt;
    int pkt_cycles;
    int done;
    int err;
    int idle;
  } exp_t;

  typedef struct {
    txn_t t;
    int   exp_pkt;
    int   exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       hs_req;
  logic [1:0] hs_code;
  logic       hs_gnt;
  logic       hs_done;
  logic       data_req;
  logic       data_gnt;
  logic       data_done;
  logic       done_err;
  logic [6:0] buffer_occupancy;
  logic       tx_transfer_active;
  logic       tx_error;
  logic [2:0] tx_packet;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  int   xm_delay = 1;
  int   xm_len = 1;
  int   xm_phase = 0;
  int   xm_t = 0;
  logic xm_err = 1'b0;
  logic xm_never = 1'b0;
  logic xm_abort = 1'b0;

  usb_tx_sched #(.IPG_CLKS(IPG), .START_TIMEOUT(TO)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .hs_req             (hs_req),
    .hs_code            (hs_code),
    .hs_gnt             (hs_gnt),
    .hs_done            (hs_done),
    .data_req           (data_req),
    .data_gnt           (data_gnt),
    .data_done          (data_done),
    .done_err           (done_err),
    .buffer_occupancy   (buffer_occupancy),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .tx_packet          (tx_packet),
    .busy               (busy)
  );

  initial forever #5 clk = ~clk;

  // Transmitter model: after a start edge, waits xm_delay clocks, holds active xm_len clocks
  initial begin
    tx_transfer_active = 1'b0;
    tx_error = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (xm_abort) begin
        xm_phase = 0;
        tx_transfer_active = 1'b0;
        tx_error = 1'b0;
      end else
        case (xm_phase)
          0: if (tx_packet != 3'd0 && !xm_never) begin xm_phase = 1; xm_t = 0; end
          1: begin
            xm_t++;
            if (xm_t == xm_delay) begin tx_transfer_active = 1'b1; xm_phase = 2; xm_t = 0; end
          end
          2: begin
            xm_t++;
            if (xm_t == xm_len) begin tx_transfer_active = 1'b0; tx_error = xm_err; xm_phase = 3; end
          end
          default: begin tx_error = 1'b0; xm_phase = 0; end
        endcase
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic hs, input logic [1:0] code, input logic dreq, input logic [6:0] occ,
                              input int dly, input int len, input logic err, input logic never);
    txn_t t;
    t.hs = hs; t.code = code; t.dreq = dreq; t.occ = occ;
    t.dly = dly; t.len = len; t.err = err; t.never = never;
    return t;
  endfunction

  // Cycle n = sample after the n-th clock edge following request assertion
  function automatic exp_t ref_model(input txn_t t);
    exp_t e;
    e.pkt = t.hs ? (t.code == 2'd0 ? 0 : int'(t.code) + 1) : (t.occ == 7'd0 ? 0 : 1);
    if (e.pkt == 0) begin
      e.pkt_cycles = 0; e.done = 2; e.err = 1; e.idle = 1 + IPG;
    end else if (t.never) begin
      e.pkt_cycles = TO; e.done = TO + 1; e.err = 1; e.idle = e.done + IPG;
    end else begin
      e.pkt_cycles = t.dly + 1; e.done = t.dly + t.len + 2; e.err = int'(t.err); e.idle = e.done + IPG;
    end
    return e;
  endfunction

  task automatic run_txn(input txn_t t, output int got_pkt, output int got_err);
    exp_t e;
    int n = 0, gh = 0, gd = 0, dh = 0, dd = 0, nz = 0, good = 0, stray = 0;
    int gcyc = -1, dcyc = -1, idle = -1;
    e = ref_model(t);
    got_pkt = 0;
    got_err = -1;
    xm_delay = t.dly; xm_len = t.len; xm_err = t.err; xm_never = t.never;
    hs_code = t.code;
    buffer_occupancy = t.occ;
    hs_req = t.hs;
    data_req = t.dreq || !t.hs;
    while (idle < 0 && n < 400) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      hs_code = 2'($urandom);
      if ((hs_gnt || data_gnt) && gcyc < 0) gcyc = n;
      gh += int'(hs_gnt); gd += int'(data_gnt);
      dh += int'(hs_done); dd += int'(data_done);
      if (tx_packet != 3'd0) begin
        nz++;
        if (got_pkt == 0) got_pkt = int'(tx_packet);
        if (int'(tx_packet) == e.pkt) good++;
      end
      if (hs_done || data_done) begin
        if (dcyc < 0) begin dcyc = n; got_err = int'(done_err); end
        if (t.hs) hs_req = 1'b0; else data_req = 1'b0;
      end else if (done_err) stray++;
      if (n > 1 && !busy) idle = n;
    end
    chk("gnt_cycle", gcyc, 1);
    chk("gnt_owner", t.hs ? gh : gd, 1);
    chk("gnt_other", t.hs ? gd : gh, 0);
    chk("pkt_code", got_pkt, e.pkt);
    chk("pkt_cycles", nz, e.pkt_cycles);
    chk("pkt_held", good, e.pkt_cycles);
    chk("done_cycle", dcyc, e.done);
    chk("done_owner", t.hs ? dh : dd, 1);
    chk("done_other", t.hs ? dd : dh, 0);
    chk("done_err", got_err, e.err);
    chk("stray_err", stray, 0);
    chk("idle_cycle", idle, e.idle);
  endtask

  initial begin
    vec_t vecs[8];
    int gp, ge, dseen;
    vecs[0] = '{t: mk(1, 2'd1, 0, 7'd0, 3, 40, 0, 0), exp_pkt: 2, exp_err: 0};
    vecs[1] = '{t: mk(1, 2'd2, 0, 7'd0, 1, 5, 0, 0), exp_pkt: 3, exp_err: 0};
    vecs[2] = '{t: mk(1, 2'd3, 0, 7'd0, 5, 1, 1, 0), exp_pkt: 4, exp_err: 1};
    vecs[3] = '{t: mk(1, 2'd0, 0, 7'd9, 2, 2, 0, 0), exp_pkt: 0, exp_err: 1};
    vecs[4] = '{t: mk(0, 2'd0, 1, 7'd0, 2, 2, 0, 0), exp_pkt: 0, exp_err: 1};
    vecs[5] = '{t: mk(0, 2'd0, 1, 7'd10, 2, 2, 0, 1), exp_pkt: 1, exp_err: 1};
    vecs[6] = '{t: mk(0, 2'd0, 1, 7'd127, 2, 12, 1, 0), exp_pkt: 1, exp_err: 1};
    vecs[7] = '{t: mk(0, 2'd0, 1, 7'd1, 62, 3, 0, 0), exp_pkt: 1, exp_err: 0};
    n_rst = 1'b0; hs_req = 1'b0; data_req = 1'b0; hs_code = 2'd0; buffer_occupancy = 7'd0;
    repeat (2) @(negedge clk);
    chk("rst_hs_gnt", int'(hs_gnt), 0);
    chk("rst_hs_done", int'(hs_done), 0);
    chk("rst_data_gnt", int'(data_gnt), 0);
    chk("rst_data_done", int'(data_done), 0);
    chk("rst_done_err", int'(done_err), 0);
    chk("rst_tx_packet", int'(tx_packet), 0);
    chk("rst_busy", int'(busy), 0);
    n_rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].t, gp, ge);
      chk("vec_pkt", gp, vecs[i].exp_pkt);
      chk("vec_err", ge, vecs[i].exp_err);
    end
    // Both requesters at once: handshake first, data re-arbitrated after the gap
    run_txn(mk(1, 2'd3, 1, 7'd5, 3, 20, 0, 0), gp, ge);
    run_txn(mk(0, 2'd0, 1, 7'd5, 4, 10, 0, 0), gp, ge);
    chk("dual_data_pkt", gp, 1);
    // Reset while the transmitter is active
    xm_delay = 2; xm_len = 30; xm_err = 1'b0; xm_never = 1'b0;
    hs_code = 2'd2; hs_req = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    n_rst = 1'b0; xm_abort = 1'b1; hs_req = 1'b0;
    dseen = 0;
    repeat (3) begin
      @(negedge clk);
      dseen += int'(hs_done) + int'(data_done);
    end
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_pkt", int'(tx_packet), 0);
    chk("mid_rst_err", int'(done_err), 0);
    chk("mid_rst_done", dseen, 0);
    n_rst = 1'b1; xm_abort = 1'b0;
    @(negedge clk);
    run_txn(mk(1, 2'd1, 0, 7'd0, 2, 6, 0, 0), gp, ge);
    chk("post_rst_err", ge, 0);
    for (int i = 0; i < 30; i++) begin
      txn_t t;
      t = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0,
             $urandom_range(0, 3) == 0 ? 7'd0 : 7'($urandom_range(1, 127)),
             $urandom_range(1, 62), $urandom_range(1, 40), 1'($urandom_range(0, 1)),
             $urandom_range(0, 7) == 0);
      run_txn(t, gp, ge);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
